// File: rtl/state_trace_fifo_pkg.sv
// Shared definitions for the state trace FIFO: core state encoding and
// record layout helpers.
package state_trace_fifo_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_00 = 2'b00,
        ST_01 = 2'b01,
        ST_10 = 2'b10,
        ST_11 = 2'b11
    } core_state_e;

    // Record layout: {state, dwell}; dwell occupies the low CW bits.
    function automatic int unsigned ent_w(input int unsigned cw);
        return cw + STATE_W;
    endfunction

    function automatic int unsigned ent_state_lsb(input int unsigned cw);
        return cw;
    endfunction

    localparam int unsigned ENT_DWELL_LSB = 0;

endpackage

// File: rtl/state_trace_fifo_if.sv
// Sample/read bus between the core-side host and the state trace FIFO.
interface state_trace_fifo_if
    import state_trace_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CW    = 8
);
    logic                     clk_en;
    logic                     c1;
    logic                     c0;
    logic                     rd_ready;
    logic                     rd_valid;
    logic [STATE_W-1:0]       rd_state;
    logic [CW-1:0]            rd_dwell;
    logic [$clog2(DEPTH):0]   count;
    logic                     overflow;

    modport master (
        output clk_en, c1, c0, rd_ready,
        input  rd_valid, rd_state, rd_dwell, count, overflow
    );

    modport slave (
        input  clk_en, c1, c0, rd_ready,
        output rd_valid, rd_state, rd_dwell, count, overflow
    );
endinterface

// File: rtl/state_trace_fifo_sync_fifo.sv
// Single-clock show-ahead FIFO; full/empty derived from the entry count.
module sync_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = AW + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);
    // A pop in the same cycle frees a slot, so a push into a full FIFO is accepted.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Storage write; contents are don't-care while not counted.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy tracking; pointers wrap modulo DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/state_trace_fifo.sv
// Core state dwell monitor: records {state, dwell} on every sampled state
// change into a show-ahead FIFO drained through a valid/ready port.
module state_trace_fifo
    import state_trace_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CW    = 8
) (
    input  logic               clk,
    input  logic               reset,
    state_trace_fifo_if.slave  bus
);
    localparam int unsigned EW = ent_w(CW);

    core_state_e        cur_state;
    logic [CW-1:0]      dwell;
    logic               primed;
    logic               overflow;
    logic [STATE_W-1:0] s;
    logic               push_req;
    logic               pop_req;
    logic               full;
    logic               empty;
    logic [EW-1:0]      din;
    logic [EW-1:0]      dout;

    assign s        = {bus.c1, bus.c0};
    assign push_req = bus.clk_en && primed && (s != cur_state);
    assign pop_req  = !empty && bus.rd_ready;
    assign din      = {cur_state, dwell};

    // Sampler and saturating dwell counter for the currently open run.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state <= ST_00;
            dwell     <= '0;
            primed    <= 1'b0;
        end else if (bus.clk_en) begin
            if (!primed) begin
                cur_state <= core_state_e'(s);
                dwell     <= CW'(1);
                primed    <= 1'b1;
            end else if (s == cur_state) begin
                if (dwell != '1) dwell <= dwell + 1'b1;
            end else begin
                cur_state <= core_state_e'(s);
                dwell     <= CW'(1);
            end
        end
    end

    // Sticky drop flag: push into a full FIFO with no concurrent pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (push_req && full && !pop_req) begin
            overflow <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .din   (din),
        .pop   (pop_req),
        .dout  (dout),
        .full  (full),
        .empty (empty),
        .count (bus.count)
    );

    assign bus.rd_valid = !empty;
    assign bus.rd_state = dout[ent_state_lsb(CW) +: STATE_W];
    assign bus.rd_dwell = dout[ENT_DWELL_LSB +: CW];
    assign bus.overflow = overflow;
endmodule

// File: tb/tb_state_trace_fifo.sv
// Testbench for state_trace_fifo: queue-based reference model checked every
// cycle, plus literal expectations from hand-worked scenarios.
module tb_state_trace_fifo;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = 4;
    localparam int MAXD = (1 << CW) - 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    state_trace_fifo_if #(.DEPTH(DEPTH), .CW(CW)) bus ();

    state_trace_fifo #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: list of records, open run, sticky drop flag.
    logic [CW+1:0] m_q[$];
    int            m_cur;
    int            m_dwell;
    bit            m_primed;
    bit            m_ovf;
    bit            chk_on = 1'b0;

    always @(posedge clk) begin
        int  sv;
        bit  pop;
        bit  push;
        logic [CW+1:0] rec;
        if (reset) begin
            m_q.delete();
            m_cur = 0; m_dwell = 0; m_primed = 0; m_ovf = 0;
            chk_on = 1'b1;
        end else begin
            sv   = {bus.c1, bus.c0};
            pop  = (m_q.size() > 0) && bus.rd_ready;
            push = 0;
            rec  = '0;
            if (bus.clk_en) begin
                if (!m_primed) begin
                    m_cur = sv; m_dwell = 1; m_primed = 1;
                end else if (sv == m_cur) begin
                    m_dwell = (m_dwell >= MAXD) ? MAXD : m_dwell + 1;
                end else begin
                    push = 1;
                    rec  = {2'(m_cur), CW'(m_dwell)};
                    m_cur = sv; m_dwell = 1;
                end
            end
            if (pop) void'(m_q.pop_front());
            if (push) begin
                if (m_q.size() < DEPTH) m_q.push_back(rec);
                else m_ovf = 1;
            end
        end
    end

    // Every-cycle comparison of the read port against the model.
    always @(negedge clk) begin
        logic [CW+1:0] head;
        if (chk_on) begin
            head = (m_q.size() > 0) ? m_q[0] : '0;
            chk("model_rd_valid", int'(bus.rd_valid), int'(m_q.size() > 0));
            chk("model_count", int'(bus.count), m_q.size());
            chk("model_overflow", int'(bus.overflow), int'(m_ovf));
            chk("model_rd_state", int'(bus.rd_state), int'(head[CW +: 2]));
            chk("model_rd_dwell", int'(bus.rd_dwell), int'(head[CW-1:0]));
        end
    end

    // One clock edge with the given inputs; returns just after that edge.
    task automatic drive(input bit rst, input bit en, input int st, input bit rdy);
        logic [1:0] sv;
        @(negedge clk);
        sv = st[1:0];
        reset      = rst;
        bus.clk_en = en;
        bus.c1     = sv[1];
        bus.c0     = sv[0];
        bus.rd_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic port(input string tag, input int v, input int st, input int dw, input int cnt, input int ov);
        chk({tag, "_valid"}, int'(bus.rd_valid), v);
        chk({tag, "_state"}, int'(bus.rd_state), st);
        chk({tag, "_dwell"}, int'(bus.rd_dwell), dw);
        chk({tag, "_count"}, int'(bus.count), cnt);
        chk({tag, "_ovf"},   int'(bus.overflow), ov);
    endtask

    initial begin
        bus.clk_en = 0; bus.c1 = 0; bus.c0 = 0; bus.rd_ready = 0;

        // Reset held 3 cycles, then 4 enabled samples of state 00.
        repeat (3) drive(1, 1, 0, 0);
        port("reset", 0, 0, 0, 0, 0);
        repeat (4) drive(0, 1, 0, 0);
        port("prime", 0, 0, 0, 0, 0);
        chk("prime_dwell", int'(dut.dwell), 4);

        // 00 x3 then 01: record {00,3}, then pop.
        drive(1, 0, 0, 0);
        repeat (3) drive(0, 1, 0, 0);
        drive(0, 1, 1, 0);
        port("change", 1, 0, 3, 1, 0);
        drive(0, 0, 1, 1);
        port("pop", 0, 0, 0, 0, 0);
        drive(0, 0, 1, 1);
        port("pop_empty", 0, 0, 0, 0, 0);

        // Enable gating: 10 held, 5 of 10 cycles enabled, then 11.
        drive(1, 0, 0, 0);
        for (int i = 0; i < 10; i++) drive(0, (i % 2) == 0, 2, 0);
        drive(0, 1, 3, 0);
        port("gate", 1, 2, 5, 1, 0);

        // Saturation: 01 for 20 enabled samples, then 00.
        drive(1, 0, 0, 0);
        repeat (20) drive(0, 1, 1, 0);
        drive(0, 1, 0, 0);
        port("sat", 1, 1, MAXD, 1, 0);

        // Overflow: prime 00, then 6 changes with no reads.
        drive(1, 0, 0, 0);
        drive(0, 1, 0, 0);
        for (int i = 1; i <= 6; i++) drive(0, 1, i % 2, 0);
        port("ovf", 1, 0, 1, 4, 1);
        for (int i = 0; i < 4; i++) begin
            chk("ovf_rd_state", int'(bus.rd_state), i % 2);
            chk("ovf_rd_dwell", int'(bus.rd_dwell), 1);
            drive(0, 0, 0, 1);
        end
        port("ovf_drain", 0, 0, 0, 0, 1);

        // Same, but the 5th change coincides with a pop.
        drive(1, 0, 0, 0);
        drive(0, 1, 0, 0);
        for (int i = 1; i <= 4; i++) drive(0, 1, i % 2, 0);
        port("full4", 1, 0, 1, 4, 0);
        drive(0, 1, 1, 1);
        port("full_pp", 1, 1, 1, 4, 0);

        // Reset mid-run with 3 entries queued and an open run.
        drive(1, 0, 0, 0);
        drive(0, 1, 0, 0);
        drive(0, 1, 1, 0);
        drive(0, 1, 2, 0);
        drive(0, 1, 3, 0);
        drive(0, 1, 3, 0);
        port("midq", 1, 0, 1, 3, 0);
        drive(1, 1, 3, 1);
        port("midrst", 0, 0, 0, 0, 0);
        drive(0, 1, 2, 0);
        drive(0, 1, 2, 0);
        drive(0, 1, 1, 0);
        port("reprime", 1, 2, 2, 1, 0);

        repeat (2) drive(0, 0, 0, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/state_trace_fifo.md
# state_trace_fifo

Downstream monitor for the processor core. Each clock-enabled cycle it samples the core's 2-bit state output `{c1,c0}`, measures how many enabled samples the core stays in each state (the dwell), and on every state change pushes one `{state, dwell}` record into a small show-ahead FIFO. A host or testbench drains the FIFO through a valid/ready read port. The block shares the core's `clk`, `clk_en` and `reset`, so its samples line up cycle-for-cycle with core state updates.

## Interface
Parameters:
- `DEPTH`, default 8: FIFO entries; power of 2, at least 2.
- `CW`, default 8: dwell counter width; saturating.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high; clears all state on the next rising edge.
- `clk_en`  in  1  sample enable, the same signal that drives the core.
- `c1`, `c0`  in  1 each  core state bits; sampled state = `{c1,c0}`.
- `rd_ready`  in  1  consumer accepts the head entry.
- `rd_valid`  out  1  FIFO not empty.
- `rd_state`  out  2  state field of the head entry.
- `rd_dwell`  out  CW  dwell field of the head entry.
- `count`  out  $clog2(DEPTH)+1  current number of entries.
- `overflow`  out  1  sticky; a record was dropped because the FIFO was full.

## Operation
- Registers: `cur_state` (2 b), `dwell` (CW b), `primed` (1 b), the FIFO storage and pointers, and `overflow`.
- Reset values: `cur_state` = 0, `dwell` = 0, `primed` = 0, FIFO empty, `count` = 0, `rd_valid` = 0, `overflow` = 0. `rd_state` and `rd_dwell` are 0 while empty.
- Cycles with `clk_en` = 0: no sampling, no change to `dwell`, `cur_state` or `primed`. The read port keeps operating.
- Cycles with `clk_en` = 1, in priority order (`s` is the sampled state):
  - `primed` = 0: `cur_state` <= s, `dwell` <= 1, `primed` <= 1. No push.
  - s == `cur_state`: `dwell` <= min(`dwell` + 1, 2^CW − 1). Saturates and never wraps.
  - s != `cur_state`: push `{cur_state, dwell}`, then `cur_state` <= s and `dwell` <= 1.
- Push when full with no pop in the same cycle: the record is dropped and `overflow` <= 1. FIFO contents are unchanged.
- Pop: occurs when `rd_valid` && `rd_ready`. The head advances on that edge.
- Simultaneous push and pop:
  - Both are performed.
  - When full, the pop frees a slot, so the push is accepted and `overflow` is not set.
  - `count` is unchanged.
- `rd_ready` while empty has no effect.
- Pointers wrap modulo DEPTH. Full/empty are decided by `count` (or an extra pointer MSB).
- `overflow` clears only on `reset`.

## Timing
- Change detection: a state change sampled at edge N makes the record visible at the head at edge N+1, if the FIFO was empty. Write-to-read latency is 1 cycle.
- Read data is show-ahead. `rd_state` and `rd_dwell` are valid combinationally from registers whenever `rd_valid` = 1, with no added read latency.
- The read port is back-to-back capable: one pop per cycle while `rd_valid` and `rd_ready` stay high.
- `count` reflects pushes and pops on the edge after they occur.
- Reset mid-operation:
  - A reset asserted on edge N takes priority over a push or pop on edge N.
  - All entries are discarded, and the partially counted dwell is discarded without a push.
  - The first enabled sample after reset re-primes the block.
- The still-open run (`cur_state`/`dwell`) is never pushed until the next change.

## Structure
- Shared header `trace_defs.vh`: `STATE_W` = 2, entry field offsets (`ENT_STATE_LSB` = CW, `ENT_DWELL_LSB` = 0), entry width macro `ENT_W(cw)` = CW + 2.
- One sub-module, `sync_fifo`:
  - Parameters: width, depth.
  - Ports: push/pop, full/empty, count.
  - Show-ahead output.
- The top level holds the sampler, dwell counter, primed flag and overflow logic, and instantiates `sync_fifo`.

## Test plan
- Reset/prime: hold reset 3 cycles, release, core state 00 for 4 enabled cycles → `rd_valid` = 0, `count` = 0, internal `dwell` = 4, `overflow` = 0.
- Change record: state 00 for 3 enabled cycles, then 01 → one cycle later `rd_valid` = 1, `rd_state` = 00, `rd_dwell` = 3, `count` = 1. Pop with `rd_ready` = 1 → `count` = 0.
- Enable gating: state 10 held; `clk_en` alternates 1/0 over 10 cycles (5 enabled), then state 11 → record `{10, 5}`.
- Saturation (CW = 4): state 01 for 20 enabled cycles, then 00 → record `{01, 15}`.
- Full/overflow (DEPTH = 4): with `rd_ready` = 0, toggle 00/01 each enabled cycle to cause 6 changes → `count` = 4, `overflow` = 1, and the first 4 records read back in order. Repeat with `rd_ready` = 1 on the 5th change → no overflow, `count` stays 4.
- Reset mid-run: 3 entries queued, assert reset for 1 cycle → `count` = 0, `rd_valid` = 0, `overflow` = 0. The next change after re-prime yields dwell counted from the first post-reset sample.
